i2s_tx: RTL and testbench



---
 rtl/i2s_tx.sv | 112 +++++++++++
 tb/tb_i2s_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-entry sample buffer feeding a stereo frame serialiser,
// with bit clock and word select divided down from the system clock.
module i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int SLOT_W    = 16,
    parameter int SCK_DIV   = 4,
    parameter int DUP_RIGHT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_vld,
    output logic                     din_rdy,
    output logic                     sck,
    output logic                     ws,
    output logic                     sd,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int BIT_CW  = $clog2(FRAME_W);
    localparam int DIV_CW  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(SCK_DIV - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(FRAME_W - 1);
    localparam logic [BIT_CW-1:0] WS_LO    = BIT_CW'(SLOT_W - 1);
    localparam logic [BIT_CW-1:0] WS_HI    = BIT_CW'(FRAME_W - 2);

    logic [DIV_CW-1:0]         div_cnt;
    logic [BIT_CW-1:0]         bit_cnt;
    logic [BIT_CW-1:0]         bit_nxt;
    logic [FRAME_W-1:0]        shreg;
    logic [FRAME_W-1:0]        frame_nxt;
    logic signed [DATA_W-1:0]  hold;
    logic                      full;
    logic                      fe;
    logic                      load;
    logic                      hs;

    // Left-justify the sample in its slot; the right slot mirrors it or stays silent.
    function automatic logic [FRAME_W-1:0] build_frame(input logic signed [DATA_W-1:0] s);
        logic [SLOT_W-1:0] slot;
        slot = '0;
        slot[SLOT_W-1 -: DATA_W] = s;
        return (DUP_RIGHT != 0) ? {slot, slot} : {slot, {SLOT_W{1'b0}}};
    endfunction

    assign din_rdy   = ~full;
    assign hs        = din_vld & ~full;
    assign fe        = (div_cnt == DIV_LAST) & sck;
    assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_CW'(1);
    assign load      = fe & (bit_cnt == BIT_LAST);
    assign frame_nxt = full ? build_frame(hold) : '0;

    // Bit clock divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_CW'(1);
        end
    end

    // Serialiser: sd and ws only move on sck falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= BIT_LAST;
            ws          <= 1'b0;
            sd          <= 1'b0;
            shreg       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load & ~full;
            if (fe) begin
                bit_cnt <= bit_nxt;
                ws      <= (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);
                if (load) begin
                    sd    <= frame_nxt[FRAME_W-1];
                    shreg <= {frame_nxt[FRAME_W-2:0], 1'b0};
                end else begin
                    sd    <= shreg[FRAME_W-1];
                    shreg <= {shreg[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    // A load from empty may coincide with a capture; the new sample waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (hs) begin
            full <= 1'b1;
        end else if (load) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            hold <= din;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: decodes sck/ws/sd like an I2S receiver and checks frames,
// flags and handshake timing against a cycle-count model of the frame schedule.
module tb_i2s_tx;

    localparam int FRAME_CYC  = 4 * 16 * 4;
    localparam int FRAME2_CYC = 4 * 24 * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_vld = 1'b0;
    logic        din_rdy, sck, ws, sd, frame_start, underrun;
    logic [15:0] din2 = '0;
    logic        din2_vld = 1'b0;
    logic        din2_rdy, sck2, ws2, sd2, frame_start2, underrun2;

    int checks = 0;
    int failures = 0;

    i2s_tx dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .sck(sck), .ws(ws), .sd(sd), .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx #(.DATA_W(16), .SLOT_W(24), .SCK_DIV(4), .DUP_RIGHT(0)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_vld(din2_vld), .din_rdy(din2_rdy),
        .sck(sck2), .ws(ws2), .sd(sd2), .frame_start(frame_start2), .underrun(underrun2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Receiver side: capture ws/sd at each sck rising edge, plus frame flags.
    logic rx_sd[$], rx_ws[$], rx2_sd[$], rx2_ws[$], obs_under[$];
    int   fs2_cyc[$];
    logic prev_sck = 1'b0, prev_sck2 = 1'b0;
    int   cyc_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_sd.delete(); rx_ws.delete(); rx2_sd.delete(); rx2_ws.delete();
            obs_under.delete(); fs2_cyc.delete();
            prev_sck <= 1'b0; prev_sck2 <= 1'b0; cyc_n <= 0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (sck && !prev_sck) begin rx_sd.push_back(sd); rx_ws.push_back(ws); end
            if (sck2 && !prev_sck2) begin rx2_sd.push_back(sd2); rx2_ws.push_back(ws2); end
            prev_sck  <= sck;
            prev_sck2 <= sck2;
            if (frame_start) obs_under.push_back(underrun);
            if (frame_start2) fs2_cyc.push_back(cyc_n + 1);
        end
    end

    // Frame schedule model: loads every FRAME_CYC clocks starting at cycle 8 after release.
    int   m_cyc = 0, m_sent = 0;
    logic m_full = 1'b0;
    logic exp_under[$];

    function automatic bit is_load(input int c);
        return (c >= 8) && (((c - 8) % FRAME_CYC) == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0; m_full <= 1'b0; m_sent <= 0; exp_under.delete();
        end else begin
            m_cyc <= m_cyc + 1;
            if (is_load(m_cyc + 1)) begin
                exp_under.push_back(!m_full);
                if (m_full) m_sent <= m_sent + 1;
            end
            if (din_vld && !m_full) m_full <= 1'b1;
            else if (is_load(m_cyc + 1) && m_full) m_full <= 1'b0;
        end
    end

    function automatic logic [15:0] rx_word(input int f, input int s);
        logic [15:0] w;
        int base;
        base = 1 + f * 32 + s * 16;
        w = 'x;
        if (rx_sd.size() >= base + 16)
            for (int i = 0; i < 16; i++) w[15-i] = rx_sd[base+i];
        return w;
    endfunction

    function automatic logic [31:0] rx_ws_frame(input int f);
        logic [31:0] w;
        int base;
        base = 1 + f * 32;
        w = 'x;
        if (rx_ws.size() >= base + 32)
            for (int i = 0; i < 32; i++) w[31-i] = rx_ws[base+i];
        return w;
    endfunction

    function automatic logic [23:0] rx2_word(input int f, input int s);
        logic [23:0] w;
        int base;
        base = 1 + f * 48 + s * 24;
        w = 'x;
        if (rx2_sd.size() >= base + 24)
            for (int i = 0; i < 24; i++) w[23-i] = rx2_sd[base+i];
        return w;
    endfunction

    function automatic logic obs_flag(input int f);
        return (f < obs_under.size()) ? obs_under[f] : 1'bx;
    endfunction

    task automatic apply_reset(input int n);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (n) @(negedge clk);
        din_vld = 1'b0; din2_vld = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic wait_rises(input int n, input bit second);
        int t;
        t = 0;
        while (((second ? rx2_sd.size() : rx_sd.size()) < n) && t < 20000) begin
            @(negedge clk); t++;
        end
        if (t >= 20000) begin
            checks++; failures++;
            $display("FAIL wait_rises got=%0d want=%0d",
                     second ? rx2_sd.size() : rx_sd.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        logic sck3, sck4, fs7, fs8, ur8;
        apply_reset(2);
        repeat (100) @(negedge clk);
        din = 16'h5555; din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        checks++;
        if (din_rdy !== 1'b0) begin failures++; $display("FAIL rst_pre_full got=%b want=0", din_rdy); end
        #2 rst = 1'b1;
        #1;
        outs = {sck, ws, sd, frame_start, underrun};
        checks++;
        if (outs !== 5'b0) begin failures++; $display("FAIL rst_async_outs got=%b want=00000", outs); end
        checks++;
        if (din_rdy !== 1'b1) begin failures++; $display("FAIL rst_async_rdy got=%b want=1", din_rdy); end
        din = 16'hBEEF; din_vld = 1'b1;
        repeat (5) @(negedge clk);
        outs = {sck, ws, sd, frame_start, underrun};
        checks++;
        if (outs !== 5'b0 || din_rdy !== 1'b1) begin
            failures++; $display("FAIL rst_held got=%b rdy=%b want=00000 rdy=1", outs, din_rdy);
        end
        din_vld = 1'b0;
        #2 rst = 1'b0;
        sck3 = 1'bx; sck4 = 1'bx; fs7 = 1'bx; fs8 = 1'bx; ur8 = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) sck3 = sck;
            if (k == 4) sck4 = sck;
            if (k == 7) fs7 = frame_start;
            if (k == 8) begin fs8 = frame_start; ur8 = underrun; end
        end
        checks++;
        if ({sck3, sck4} !== 2'b01) begin failures++; $display("FAIL rst_sck_rise got=%b want=01", {sck3, sck4}); end
        checks++;
        if ({fs7, fs8, ur8} !== 3'b011) begin
            failures++; $display("FAIL rst_first_load got=%b want=011", {fs7, fs8, ur8});
        end
        wait_rises(33, 1'b0);
        checks++;
        if ({rx_word(0, 0), rx_word(0, 1)} !== 32'h0) begin
            failures++; $display("FAIL rst_zero_frame got=%h want=00000000", {rx_word(0, 0), rx_word(0, 1)});
        end
        checks++;
        if (obs_flag(0) !== exp_under[0]) begin
            failures++; $display("FAIL rst_underrun_flag got=%b want=%b", obs_flag(0), exp_under[0]);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_ws;
        apply_reset(3);
        din = 16'h8001; din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        checks++;
        if (din_rdy !== 1'b0) begin failures++; $display("FAIL single_rdy got=%b want=0", din_rdy); end
        wait_rises(33, 1'b0);
        checks++;
        if (rx_word(0, 0) !== 16'h8001) begin failures++; $display("FAIL single_left got=%h want=8001", rx_word(0, 0)); end
        checks++;
        if (rx_word(0, 1) !== 16'h8001) begin failures++; $display("FAIL single_right got=%h want=8001", rx_word(0, 1)); end
        for (int b = 0; b < 32; b++) exp_ws[31-b] = (b >= 15) && (b <= 30);
        checks++;
        if (rx_ws_frame(0) !== exp_ws) begin
            failures++; $display("FAIL single_ws got=%h want=%h", rx_ws_frame(0), exp_ws);
        end
        checks++;
        if (obs_flag(0) !== 1'b0) begin failures++; $display("FAIL single_underrun got=%b want=0", obs_flag(0)); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s[3];
        int t;
        s[0] = 16'h1234; s[1] = 16'hFEDC; s[2] = 16'h0F0F;
        apply_reset(3);
        din_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = s[i];
            t = 0;
            while (!din_rdy && t < 1000) begin @(negedge clk); t++; end
            checks++;
            if (t >= 1000) begin failures++; $display("FAIL b2b_rdy_timeout idx=%0d got=%0d want<1000", i, t); end
            if (i > 0) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    failures++; $display("FAIL b2b_rdy_after_load idx=%0d frame_start=%b want=1", i, frame_start);
                end
            end
            @(negedge clk);
            checks++;
            if (din_rdy !== 1'b0) begin failures++; $display("FAIL b2b_rdy_drop idx=%0d got=%b want=0", i, din_rdy); end
        end
        din_vld = 1'b0;
        wait_rises(1 + 3 * 32, 1'b0);
        for (int f = 0; f < 3; f++) begin
            checks++;
            if ({rx_word(f, 0), rx_word(f, 1)} !== {s[f], s[f]}) begin
                failures++; $display("FAIL b2b_frame%0d got=%h want=%h", f, {rx_word(f, 0), rx_word(f, 1)}, {s[f], s[f]});
            end
            checks++;
            if (obs_flag(f) !== 1'b0) begin failures++; $display("FAIL b2b_underrun%0d got=%b want=0", f, obs_flag(f)); end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(3);
        repeat (7) @(negedge clk);
        din = 16'h7FFF; din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        checks++;
        if ({frame_start, underrun, din_rdy} !== 3'b110) begin
            failures++; $display("FAIL simul_load got=%b want=110", {frame_start, underrun, din_rdy});
        end
        wait_rises(65, 1'b0);
        checks++;
        if ({rx_word(0, 0), rx_word(0, 1)} !== 32'h0) begin
            failures++; $display("FAIL simul_frame0 got=%h want=00000000", {rx_word(0, 0), rx_word(0, 1)});
        end
        checks++;
        if ({rx_word(1, 0), rx_word(1, 1)} !== 32'h7FFF7FFF) begin
            failures++; $display("FAIL simul_frame1 got=%h want=7fff7fff", {rx_word(1, 0), rx_word(1, 1)});
        end
        checks++;
        if ({obs_flag(0), obs_flag(1)} !== 2'b10) begin
            failures++; $display("FAIL simul_flags got=%b want=10", {obs_flag(0), obs_flag(1)});
        end
    endtask

    task automatic test_dup0_slot24();
        int t, bad;
        apply_reset(3);
        din2 = 16'hA5A5; din2_vld = 1'b1;
        @(negedge clk);
        din2_vld = 1'b0;
        wait_rises(1 + 48, 1'b1);
        t = 0;
        while (fs2_cyc.size() < 2 && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (rx2_word(0, 0) !== 24'hA5A500) begin failures++; $display("FAIL d0_left got=%h want=a5a500", rx2_word(0, 0)); end
        checks++;
        if (rx2_word(0, 1) !== 24'h0) begin failures++; $display("FAIL d0_right got=%h want=000000", rx2_word(0, 1)); end
        bad = 0;
        for (int b = 0; b < 48; b++)
            if (rx2_ws[1+b] !== ((b >= 23) && (b <= 46))) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL d0_ws got=%0d_bad_bits want=0", bad); end
        checks++;
        if (fs2_cyc.size() < 2) begin
            failures++; $display("FAIL d0_frame_period got=%0d_starts want=2", fs2_cyc.size());
        end else if (fs2_cyc[0] !== 8 || (fs2_cyc[1] - fs2_cyc[0]) !== FRAME2_CYC) begin
            failures++; $display("FAIL d0_frame_period got=%0d,%0d want=8,%0d", fs2_cyc[0], fs2_cyc[1] - fs2_cyc[0], FRAME2_CYC);
        end
    endtask

    task automatic test_loopback_random();
        logic [15:0] samples[200];
        int t, nf, k;
        apply_reset(3);
        for (int i = 0; i < 200; i++) samples[i] = 16'($urandom);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 300)) @(negedge clk);
            din = samples[i]; din_vld = 1'b1;
            t = 0;
            while (!din_rdy && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) begin
                checks++; failures++; $display("FAIL loop_rdy_timeout idx=%0d got=%0d want<2000", i, t);
            end
            @(negedge clk);
            din_vld = 1'b0;
        end
        t = 0;
        while (m_sent < 200 && t < 2000) begin @(negedge clk); t++; end
        nf = exp_under.size();
        wait_rises(1 + nf * 32, 1'b0);
        k = 0;
        for (int f = 0; f < nf; f++) begin
            checks++;
            if (obs_flag(f) !== exp_under[f]) begin
                failures++; $display("FAIL loop_flag f=%0d got=%b want=%b", f, obs_flag(f), exp_under[f]);
            end
            checks++;
            if (exp_under[f]) begin
                if ({rx_word(f, 0), rx_word(f, 1)} !== 32'h0) begin
                    failures++; $display("FAIL loop_idle f=%0d got=%h want=00000000", f, {rx_word(f, 0), rx_word(f, 1)});
                end
            end else begin
                if (k >= 200 || {rx_word(f, 0), rx_word(f, 1)} !== {samples[k], samples[k]}) begin
                    failures++; $display("FAIL loop_data f=%0d got=%h want=%h", f, {rx_word(f, 0), rx_word(f, 1)},
                                         (k < 200) ? {samples[k], samples[k]} : 32'hx);
                end
                k++;
            end
        end
        checks++;
        if (k !== 200) begin failures++; $display("FAIL loop_count got=%0d want=200", k); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_dup0_slot24();
        test_loopback_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
